// File: rtl/vram_cmd_if.sv
// Byte-stream input and VRAM write-port bundle for vram_cmd_ctrl.
// master = the controller, slave = the UART/VRAM side that drives the bytes.
interface vram_cmd_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 6
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ack;
  logic              vblank;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic              busy;
  logic              cmd_err;

  modport master (
    input  byte_in, byte_valid, vblank,
    output byte_ack, vram_we, vram_addr, vram_wdata, busy, cmd_err
  );

  modport slave (
    output byte_in, byte_valid, vblank,
    input  byte_ack, vram_we, vram_addr, vram_wdata, busy, cmd_err
  );
endinterface

// File: rtl/vram_cmd_ctrl.sv
// Byte-protocol command sequencer driving the VRAM write port (SET_ADDR, WRITE, FILL, CLEAR).
// Optional VBLANK_GATE_EN: writes and DATA-byte consumption only while vblank is high.
module vram_cmd_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 6,
  parameter int DEPTH  = 30000
) (
  input  logic       clk,
  input  logic       rst,
  vram_cmd_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, FILL_VAL, DATA, FILL_RUN, CLEAR_RUN
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       CLEAR_LEN = 16'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              is_fill_q, is_fill_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              byte_avail, wr_ok, consume;
  logic [ADDR_W-1:0] ptr_inc, set_val;
  logic [15:0]       len_full;

  // A byte acked last cycle is still on byte_in; it must not be taken again.
  assign byte_avail = bus.byte_valid & ~ack_q;
  assign ptr_inc    = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
  assign set_val    = ADDR_W'({hi_q, bus.byte_in});
  assign len_full   = {len_q[15:8], bus.byte_in};

`ifdef VBLANK_GATE_EN
  assign wr_ok = bus.vblank;
`else
  logic unused_vblank;
  assign unused_vblank = bus.vblank;
  assign wr_ok         = 1'b1;
`endif

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      hi_q      <= '0;
      val_q     <= '0;
      is_fill_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      val_q     <= val_d;
      is_fill_q <= is_fill_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    hi_d      = hi_q;
    val_d     = val_q;
    is_fill_d = is_fill_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    consume   = 1'b0;
    err_d     = 1'b0;
    we_d      = 1'b0;

    case (state_q)
      IDLE: if (byte_avail) begin
        consume = 1'b1;
        case (bus.byte_in)
          8'h01: state_d = ADDR_HI;
          8'h02: begin state_d = LEN_HI; is_fill_d = 1'b0; end
          8'h03: begin state_d = LEN_HI; is_fill_d = 1'b1; end
          8'h04: begin
            state_d = CLEAR_RUN;
            ptr_d   = '0;
            len_d   = CLEAR_LEN;
            val_d   = '0;
          end
          default: err_d = 1'b1;
        endcase
      end
      ADDR_HI: if (byte_avail) begin
        consume = 1'b1;
        hi_d    = bus.byte_in;
        state_d = ADDR_LO;
      end
      ADDR_LO: if (byte_avail) begin
        consume = 1'b1;
        state_d = IDLE;
        if (set_val > LAST_ADDR) begin
          ptr_d = '0;
          err_d = 1'b1;
        end else begin
          ptr_d = set_val;
        end
      end
      LEN_HI: if (byte_avail) begin
        consume = 1'b1;
        len_d   = {bus.byte_in, 8'h00};
        state_d = LEN_LO;
      end
      LEN_LO: if (byte_avail) begin
        consume = 1'b1;
        len_d   = len_full;
        if (is_fill_q)          state_d = FILL_VAL;
        else if (len_full == 0) state_d = IDLE;
        else                    state_d = DATA;
      end
      FILL_VAL: if (byte_avail) begin
        consume = 1'b1;
        val_d   = bus.byte_in[DATA_W-1:0];
        state_d = (len_q == 0) ? IDLE : FILL_RUN;
      end
      // Run states linger one cycle at len 0 so the last registered write is seen outside IDLE.
      DATA: begin
        if (len_q == 0) begin
          state_d = IDLE;
        end else if (byte_avail && wr_ok) begin
          consume = 1'b1;
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = bus.byte_in[DATA_W-1:0];
          ptr_d   = ptr_inc;
          len_d   = len_q - 1'b1;
        end
      end
      FILL_RUN, CLEAR_RUN: begin
        if (len_q == 0) begin
          state_d = IDLE;
        end else if (wr_ok) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = val_q;
          ptr_d   = ptr_inc;
          len_d   = len_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ack_d = consume;
  end

  always_comb begin
    bus.byte_ack   = ack_q;
    bus.cmd_err    = err_q;
    bus.vram_we    = we_q;
    bus.vram_addr  = addr_q;
    bus.vram_wdata = wdata_q;
    bus.busy       = (state_q != IDLE);
  end

endmodule
